// File: rtl/traffic_light_monitor.sv
// Passive checker for the highway/byroad traffic light lamps. It decodes the lamp
// pattern into a phase, enforces phase order, dwell limits and a watchdog, and latches the first fault.
module traffic_light_monitor #(
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 4,
  parameter int MAX_PHASE  = 63
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_h_red,
  input  logic       i_h_yellow,
  input  logic       i_h_green,
  input  logic       i_b_red,
  input  logic       i_b_yellow,
  input  logic       i_b_green,
  input  logic       i_fault_clr,
  output logic [1:0] o_phase,
  output logic       o_synced,
  output logic       o_fault,
  output logic [2:0] o_fault_code,
  output logic [7:0] o_cycles
);

  typedef enum logic [1:0] {
    PH_HG = 2'd0,
    PH_HY = 2'd1,
    PH_BG = 2'd2,
    PH_BY = 2'd3
  } phase_e;

  typedef enum logic {
    ST_UNSYNCED = 1'b0,
    ST_SYNCED   = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE       = 3'd0,
    FC_PATTERN    = 3'd1,
    FC_TRANSITION = 3'd2,
    FC_YELLOW     = 3'd3,
    FC_GREEN      = 3'd4,
    FC_WATCHDOG   = 3'd5
  } fault_e;

  localparam logic [7:0] LP_MIN_GREEN  = 8'(MIN_GREEN);
  localparam logic [7:0] LP_MIN_YELLOW = 8'(MIN_YELLOW);
  localparam logic [7:0] LP_MAX_PHASE  = 8'(MAX_PHASE);

  state_e     r_state;
  phase_e     r_phase;
  logic [7:0] r_dwell;
  logic       r_first;
  logic       r_fault;
  fault_e     r_fault_code;
  logic [7:0] r_cycles;

  state_e     w_state_nxt;
  phase_e     w_phase_nxt;
  logic [7:0] w_dwell_nxt;
  logic       w_first_nxt;
  logic       w_fault_nxt;
  fault_e     w_fault_code_nxt;
  logic [7:0] w_cycles_nxt;

  logic [5:0] w_lamps;
  logic       w_valid;
  phase_e     w_dec_phase;
  phase_e     w_succ_phase;
  logic       w_same;
  logic       w_legal;
  logic       w_in_yellow;
  fault_e     w_detect;

  assign w_lamps = {i_h_red, i_h_yellow, i_h_green, i_b_red, i_b_yellow, i_b_green};

  // Exactly two lamps lit, one per road; every other combination is invalid.
  always_comb begin
    w_valid     = 1'b1;
    w_dec_phase = PH_HG;
    case (w_lamps)
      6'b001_100: w_dec_phase = PH_HG;
      6'b010_100: w_dec_phase = PH_HY;
      6'b100_001: w_dec_phase = PH_BG;
      6'b100_010: w_dec_phase = PH_BY;
      default:    w_valid     = 1'b0;
    endcase
  end

  assign w_succ_phase = phase_e'(r_phase + 2'd1);
  assign w_same       = (w_dec_phase == r_phase);
  assign w_legal      = (w_dec_phase == w_succ_phase);
  assign w_in_yellow  = (r_phase == PH_HY) || (r_phase == PH_BY);

  // The if-chain order gives the fault priority; dwell limits are waived for the partial first phase.
  always_comb begin
    w_detect = FC_NONE;
    if (r_state == ST_SYNCED) begin
      if (!w_valid) begin
        w_detect = FC_PATTERN;
      end else if (!w_same) begin
        if (!w_legal) begin
          w_detect = FC_TRANSITION;
        end else if (!r_first && w_in_yellow && (r_dwell < LP_MIN_YELLOW)) begin
          w_detect = FC_YELLOW;
        end else if (!r_first && !w_in_yellow && (r_dwell < LP_MIN_GREEN)) begin
          w_detect = FC_GREEN;
        end
      end else if (r_dwell >= LP_MAX_PHASE) begin
        w_detect = FC_WATCHDOG;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_dwell_nxt      = r_dwell;
    w_first_nxt      = r_first;
    w_fault_nxt      = r_fault;
    w_fault_code_nxt = r_fault_code;
    w_cycles_nxt     = r_cycles;

    case (r_state)
      ST_UNSYNCED: begin
        if (w_valid) begin
          w_state_nxt = ST_SYNCED;
          w_phase_nxt = w_dec_phase;
          w_dwell_nxt = 8'd1;
          w_first_nxt = 1'b1;
        end
      end
      ST_SYNCED: begin
        if (w_detect != FC_NONE) begin
          w_state_nxt = ST_UNSYNCED;
        end else if (w_same) begin
          if (r_dwell != 8'hFF) begin
            w_dwell_nxt = r_dwell + 8'd1;
          end
        end else begin
          w_phase_nxt = w_dec_phase;
          w_dwell_nxt = 8'd1;
          w_first_nxt = 1'b0;
          if (r_phase == PH_BY) begin
            w_cycles_nxt = r_cycles + 8'd1;
          end
        end
      end
      default: w_state_nxt = ST_UNSYNCED;
    endcase

    // A fault found on the clearing edge is recorded rather than lost.
    if (w_detect != FC_NONE) begin
      w_fault_nxt = 1'b1;
      if ((r_fault_code == FC_NONE) || i_fault_clr) begin
        w_fault_code_nxt = w_detect;
      end
    end else if (i_fault_clr) begin
      w_fault_nxt      = 1'b0;
      w_fault_code_nxt = FC_NONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_UNSYNCED;
      r_phase      <= PH_HG;
      r_dwell      <= 8'd0;
      r_first      <= 1'b1;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
      r_cycles     <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_dwell      <= w_dwell_nxt;
      r_first      <= w_first_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_code <= w_fault_code_nxt;
      r_cycles     <= w_cycles_nxt;
    end
  end

  assign o_phase      = r_phase;
  assign o_synced     = (r_state == ST_SYNCED);
  assign o_fault      = r_fault;
  assign o_fault_code = r_fault_code;
  assign o_cycles     = r_cycles;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed lamp runs push the hand-computed
// response, and a negedge monitor pops and compares one entry per sampled cycle.
module tb_traffic_light_monitor;

  typedef struct packed {
    logic [1:0] phase;
    logic       synced;
    logic       fault;
    logic [2:0] code;
    logic [7:0] cycles;
  } exp_t;

  localparam logic [5:0] HG  = 6'b001_100;
  localparam logic [5:0] HY  = 6'b010_100;
  localparam logic [5:0] BG  = 6'b100_001;
  localparam logic [5:0] BY  = 6'b100_010;
  localparam logic [5:0] OFF = 6'b000_000;
  localparam logic [5:0] BAD = 6'b101_001;

  logic       clk;
  logic       rstN;
  logic       hRed, hYellow, hGreen, bRed, bYellow, bGreen;
  logic       faultClr;
  logic [1:0] phase;
  logic       synced;
  logic       fault;
  logic [2:0] faultCode;
  logic [7:0] cycles;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  int   sampleIdx = 0;

  traffic_light_monitor #(.MIN_GREEN(8), .MIN_YELLOW(4), .MAX_PHASE(63)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_h_red      (hRed),
    .i_h_yellow   (hYellow),
    .i_h_green    (hGreen),
    .i_b_red      (bRed),
    .i_b_yellow   (bYellow),
    .i_b_green    (bGreen),
    .i_fault_clr  (faultClr),
    .o_phase      (phase),
    .o_synced     (synced),
    .o_fault      (fault),
    .o_fault_code (faultCode),
    .o_cycles     (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] p, input logic s, input logic f,
                              input logic [2:0] c, input logic [7:0] n);
    exp_t e;
    e.phase  = p;
    e.synced = s;
    e.fault  = f;
    e.code   = c;
    e.cycles = n;
    return e;
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act = mk(phase, synced, fault, faultCode, cycles);
    checks++;
    if (act === e) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got phase=%0d synced=%0b fault=%0b code=%0d cycles=%0d, expected phase=%0d synced=%0b fault=%0b code=%0d cycles=%0d",
               name, act.phase, act.synced, act.fault, act.code, act.cycles,
               e.phase, e.synced, e.fault, e.code, e.cycles);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] lamps, input int n, input logic clr, input exp_t e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {hRed, hYellow, hGreen, bRed, bYellow, bGreen} = lamps;
      faultClr = clr;
      @(posedge clk);
      expQ.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      string name;
      e = expQ.pop_front();
      name = $sformatf("sample %0d", sampleIdx);
      sampleIdx++;
      checkOutput(name, e);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstN = 1'b0;
    faultClr = 1'b0;
    {hRed, hYellow, hGreen, bRed, bYellow, bGreen} = OFF;
    #1;
    checkOutput("reset state", mk(0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(OFF, 10, 1'b0, mk(0, 0, 0, 0, 0));
    applyStimulus(HG, 1, 1'b0, mk(0, 1, 0, 0, 0));

    for (int k = 0; k < 3; k++) begin
      applyStimulus(HG, (k == 0) ? 20 : 21, 1'b0, mk(0, 1, 0, 0, 8'(k)));
      applyStimulus(HY, 11, 1'b0, mk(1, 1, 0, 0, 8'(k)));
      applyStimulus(BG, 11, 1'b0, mk(2, 1, 0, 0, 8'(k)));
      applyStimulus(BY, 6, 1'b0, mk(3, 1, 0, 0, 8'(k)));
    end
    applyStimulus(HG, 21, 1'b0, mk(0, 1, 0, 0, 3));

    applyStimulus(HY, 2, 1'b0, mk(1, 1, 0, 0, 3));
    applyStimulus(BG, 1, 1'b0, mk(1, 0, 1, 3, 3));
    applyStimulus(OFF, 2, 1'b0, mk(1, 0, 1, 3, 3));
    applyStimulus(HG, 4, 1'b0, mk(0, 1, 1, 3, 3));
    applyStimulus(HG, 1, 1'b1, mk(0, 1, 0, 0, 3));
    applyStimulus(HG, 4, 1'b0, mk(0, 1, 0, 0, 3));

    applyStimulus(HY, 4, 1'b0, mk(1, 1, 0, 0, 3));
    applyStimulus(BG, 3, 1'b0, mk(2, 1, 0, 0, 3));
    applyStimulus(BAD, 1, 1'b0, mk(2, 0, 1, 1, 3));
    applyStimulus(HG, 3, 1'b0, mk(0, 1, 1, 1, 3));
    applyStimulus(BG, 1, 1'b1, mk(0, 0, 1, 2, 3));

    applyStimulus(OFF, 1, 1'b1, mk(0, 0, 0, 0, 3));
    applyStimulus(HG, 63, 1'b0, mk(0, 1, 0, 0, 3));
    applyStimulus(HG, 1, 1'b0, mk(0, 0, 1, 5, 3));

    applyStimulus(OFF, 1, 1'b1, mk(0, 0, 0, 0, 3));
    applyStimulus(HG, 10, 1'b0, mk(0, 1, 0, 0, 3));
    applyStimulus(HY, 5, 1'b0, mk(1, 1, 0, 0, 3));
    applyStimulus(BG, 8, 1'b0, mk(2, 1, 0, 0, 3));
    applyStimulus(BY, 5, 1'b0, mk(3, 1, 0, 0, 3));
    applyStimulus(HG, 8, 1'b0, mk(0, 1, 0, 0, 4));
    applyStimulus(HY, 5, 1'b0, mk(1, 1, 0, 0, 4));
    applyStimulus(BG, 8, 1'b0, mk(2, 1, 0, 0, 4));
    applyStimulus(BY, 5, 1'b0, mk(3, 1, 0, 0, 4));
    applyStimulus(HG, 8, 1'b0, mk(0, 1, 0, 0, 5));
    applyStimulus(HY, 5, 1'b0, mk(1, 1, 0, 0, 5));
    applyStimulus(BG, 3, 1'b0, mk(2, 1, 0, 0, 5));

    @(negedge clk);
    #1 rstN = 1'b0;
    #1 checkOutput("async reset mid-BG", mk(0, 0, 0, 0, 0));
    {hRed, hYellow, hGreen, bRed, bYellow, bGreen} = OFF;
    @(posedge clk);
    #1 checkOutput("held in reset", mk(0, 0, 0, 0, 0));
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(OFF, 2, 1'b0, mk(0, 0, 0, 0, 0));
    applyStimulus(BG, 3, 1'b0, mk(2, 1, 0, 0, 0));

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() == 0) begin
      passes++;
    end else begin
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
